// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package hex_scan_pkg;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational BCD nibble to active-low a..g segment encoder; 10-15 render blank.
module seg7_lut
    import hex_scan_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [0:6] seg_o
);

    always_comb begin
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value updates,
// per-slot guard gap and optional leading-zero blanking.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [0:6]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int unsigned TickW = cnt_width(PRESCALE);
    localparam int unsigned IdxW  = cnt_width(DIGITS);
    localparam logic [TickW-1:0] TickMax = TickW'(PRESCALE - 1);
    localparam logic [IdxW-1:0]  IdxMax  = IdxW'(DIGITS - 1);

    state_t                state_q, state_d;
    logic [TickW-1:0]      tick_q, tick_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pend_full_q, pend_full_d;
    logic [0:6]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary, accept;
    logic [DIGITS-1:0]     lz_mask;
    logic                  upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_lz;
    logic [0:6]            lut_seg;

    assign load_ready = ~pend_full_q;
    assign accept     = load_valid & ~pend_full_q;
    assign boundary   = (state_q == S_SHOW) && (tick_q == TickMax) && (idx_q == IdxMax);

    // Digit i is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (active_q[4*i +: 4] == 4'd0);
            lz_mask[i] = upper_zero;
        end
    end

    always_comb begin
        cur_nib = 4'd0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib = active_q[4*i +: 4];
                cur_lz  = lz_mask[i];
            end
        end
    end

    seg7_lut u_seg7_lut (
        .digit_i (cur_nib),
        .seg_o   (lut_seg)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_GUARD: begin
                state_d = S_SHOW;
                tick_d  = TickW'(1);
            end
            S_SHOW: begin
                if (tick_q == TickMax) begin
                    state_d = S_GUARD;
                    tick_d  = '0;
                    idx_d   = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
        endcase
    end

    // A load landing on the boundary with nothing pending goes straight to active.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        if (boundary) begin
            if (pend_full_q) begin
                active_d    = pending_q;
                pend_full_d = 1'b0;
            end else if (accept) begin
                active_d = load_bcd;
            end
        end else if (accept) begin
            pending_d   = load_bcd;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        seg_d        = SEG_BLANK;
        frame_done_d = boundary;
        for (int i = 0; i < DIGITS; i++) begin
            dig_en_d[i] = ~((state_q == S_SHOW) && (idx_q == IdxW'(i)));
        end
        if (state_q == S_SHOW) begin
            seg_d = (BLANK_LZ && cur_lz) ? SEG_BLANK : lut_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_GUARD;
            tick_q       <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_en_q     <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench: a frame-arithmetic model predicts every output cycle for two
// instances (leading-zero blanking on and off) and a monitor compares them.
module tb_hex_scan_ctrl;

    localparam int DIG   = 4;
    localparam int PRE   = 4;
    localparam int FRAME = DIG * PRE;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_bcd;
    logic        load_ready1, load_ready0;
    logic [0:6]  seg1, seg0;
    logic [3:0]  dig_en1, dig_en0;
    logic        frame_done1, frame_done0;

    always #5 clk = ~clk;

    hex_scan_ctrl #(.DIGITS(DIG), .PRESCALE(PRE), .BLANK_LZ(1'b1)) u_dut_lz (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready1),
        .load_bcd   (load_bcd),
        .seg        (seg1),
        .dig_en     (dig_en1),
        .frame_done (frame_done1)
    );

    hex_scan_ctrl #(.DIGITS(DIG), .PRESCALE(PRE), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready0),
        .load_bcd   (load_bcd),
        .seg        (seg0),
        .dig_en     (dig_en0),
        .frame_done (frame_done0)
    );

    typedef struct packed {
        logic [3:0] dig_en;
        logic [6:0] seg;
        logic [6:0] seg_nolz;
        logic       frame_done;
        logic       ready;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_pend[$];
    logic [15:0] m_shown;
    int          m_cyc;
    int          n_pass = 0;
    int          n_total = 0;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b want=%b", name, m_cyc, act, exp);
    endtask

    // Reference model: slot position is plain arithmetic on the cycle count since reset.
    initial begin
        exp_t        e;
        int          p, d;
        logic        guard, accept;
        logic [3:0]  nib;
        logic [3:0]  one;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cyc   = 0;
                m_shown = '0;
                m_pend.delete();
                e = '{dig_en: 4'hF, seg: BLANK, seg_nolz: BLANK, frame_done: 1'b0, ready: 1'b1};
            end else begin
                p      = m_cyc % FRAME;
                d      = p / PRE;
                guard  = (p % PRE) == 0;
                accept = load_valid && (m_pend.size() == 0);
                nib    = m_shown[4*d +: 4];
                one    = 4'b0001;
                e.dig_en     = guard ? 4'hF : ~(one << d);
                e.seg_nolz   = guard ? BLANK : enc(nib);
                e.seg        = (guard || (d != 0 && (m_shown >> (4*d)) == 16'd0)) ? BLANK
                                                                              : enc(nib);
                e.frame_done = (p == FRAME - 1);
                if (p == FRAME - 1) begin
                    if (m_pend.size() != 0) m_shown = m_pend.pop_front();
                    else if (accept)        m_shown = load_bcd;
                end else if (accept) begin
                    m_pend.push_back(load_bcd);
                end
                e.ready = (m_pend.size() == 0);
                m_cyc++;
            end
            exp_q.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("seg_lz",      8'(seg1),        8'(e.seg));
                chk("seg_nolz",    8'(seg0),        8'(e.seg_nolz));
                chk("dig_en_lz",   8'(dig_en1),     8'(e.dig_en));
                chk("dig_en_nolz", 8'(dig_en0),     8'(e.dig_en));
                chk("frame_done",  8'(frame_done1), 8'(e.frame_done));
                chk("frame_done0", 8'(frame_done0), 8'(e.frame_done));
                chk("load_ready",  8'(load_ready1), 8'(e.ready));
                chk("load_ready0", 8'(load_ready0), 8'(e.ready));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold valid until the model says the pending slot is free, then one transfer edge.
    task automatic send(input logic [15:0] d);
        int waited = 0;
        load_valid = 1'b1;
        load_bcd   = d;
        while (m_pend.size() != 0 && waited < 100) begin
            step(1);
            waited++;
        end
        if (waited >= 100) begin
            n_total++;
            $display("FAIL send_timeout got=stalled want=accept");
        end
        step(1);
        load_valid = 1'b0;
        load_bcd   = 16'($urandom);
    endtask

    task automatic wait_pos(input int pos);
        int waited = 0;
        while ((m_cyc % FRAME) != pos && waited < 4 * FRAME) begin
            step(1);
            waited++;
        end
    endtask

    initial begin
        logic [15:0] r;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_bcd   = '0;
        step(3);
        reset = 1'b0;
        step(2 * FRAME + 3);

        send(16'h1234);
        step(2 * FRAME);

        send(16'h0007);
        send(16'h0042);
        step(3 * FRAME);

        // Accept exactly on the frame-boundary cycle with nothing pending.
        wait_pos(FRAME - 1);
        load_valid = 1'b1;
        load_bcd   = 16'h0309;
        step(1);
        load_valid = 1'b0;
        step(FRAME + 2);

        send(16'h0A05);
        step(2 * FRAME);

        for (int i = 0; i < 30; i++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 1) == 0) r = r & (16'hFFFF >> (4 * $urandom_range(1, 3)));
            step($urandom_range(0, 20));
            send(r);
        end
        step(2 * FRAME);

        // Reset mid-slot of digit 2 while a value sits in pending.
        wait_pos(1);
        send(16'h5678);
        wait_pos(2 * PRE + 2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2 * FRAME);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
